blood_ph_monitor: RTL and testbench
===================================

// Module: blood_ph_monitor
// PURPOSE
//  Sequential, parametrised successor of the combinational blood-pH abnormality checker.
//  - Classifies each pH sample against two configurable normal windows (P, Q).
//  - Debounces each classification with an N-consecutive-sample hysteresis FSM.
//  - Counts alarm episodes per channel.
//  - Sits between the pH sensor sampler and the patient-alert/display logic.
// PARAMETERS
//  PH_WIDTH   4  sample width, unsigned
//  P_LOW      6  P normal iff P_LOW < ph < P_HIGH (both bounds exclusive)
//  P_HIGH     9  upper exclusive bound, channel P
//  Q_LOW      5  lower exclusive bound, channel Q
//  Q_HIGH     10 upper exclusive bound, channel Q
//  PERSIST    3  consecutive opposite samples needed to toggle an alarm (>=1)
//  EVT_WIDTH  8  width of saturating alarm-episode counters
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          asynchronous, active-low reset
//  sample_valid  in   1          ph_in is valid this cycle
//  ph_in         in   PH_WIDTH   blood pH sample
//  clear         in   1          synchronous clear of alarms, streaks, counters
//  result_valid  out  1          one-cycle pulse: raw/alarm outputs reflect the new sample
//  raw_p         out  1          undebounced P abnormality of last sample
//  raw_q         out  1          undebounced Q abnormality of last sample
//  alarm_p       out  1          debounced P alarm
//  alarm_q       out  1          debounced Q alarm
//  evt_cnt_p     out  EVT_WIDTH  number of alarm_p 0->1 transitions (saturating)
//  evt_cnt_q     out  EVT_WIDTH  number of alarm_q 0->1 transitions (saturating)
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output, every streak counter and every FSM state = 0/NORMAL.
//  - Classification: abn_x = !(X_LOW < ph_in && ph_in < X_HIGH); unsigned, PH_WIDTH-wide compare.
//  - Latency: 1 cycle. At the edge where sample_valid=1:
//    - raw_x <= abn_x, result_valid <= 1.
//    - FSM/alarm update uses the same sample.
//    Otherwise result_valid <= 0; raw/alarm/counters hold.
//  - Per-channel FSM, states:
//    - NORMAL: abn sample -> streak=1; if PERSIST==1 go ALARM, else go PEND_ALARM.
//    - PEND_ALARM:
//      - normal sample -> NORMAL, streak=0;
//      - abn sample -> streak+1; on reaching PERSIST -> ALARM, streak=0.
//    - ALARM: normal sample -> streak=1; if PERSIST==1 go NORMAL, else go PEND_CLEAR.
//    - PEND_CLEAR:
//      - abn sample -> ALARM, streak=0;
//      - normal sample -> streak+1; on reaching PERSIST -> NORMAL, streak=0.
//    - alarm_x = 1 in ALARM and PEND_CLEAR, 0 otherwise (registered).
//  - Streak counter width: $clog2(PERSIST+1); never exceeds PERSIST.
//  - evt_cnt_x increments in the cycle alarm_x goes 0->1; holds at all-ones (saturates, no wrap).
//  - Both channels are independent; simultaneous transitions are allowed.
//  - clear=1 (sync, priority over sample_valid):
//    - next cycle all FSMs NORMAL, streaks 0, alarms 0, evt_cnts 0, raw 0, result_valid 0;
//    - a sample presented with clear is dropped.
//  - Reset mid-streak: streak is lost; after release the FSM restarts from NORMAL.
//  - Elaboration check: P_LOW<P_HIGH, Q_LOW<Q_HIGH, bounds < 2**PH_WIDTH, PERSIST>=1;
//    otherwise $error.
//  - ph_in is ignored when sample_valid=0; no X-propagation from an idle bus.
// STRUCTURE
//  - Shared include ph_defs.vh: FSM state encodings (NORMAL=2'd0, PEND_ALARM=2'd1,
//    ALARM=2'd2, PEND_CLEAR=2'd3) and the default pH window constants.
//  - One sub-module, ph_alarm_channel (params LOW, HIGH, PERSIST, EVT_WIDTH, PH_WIDTH):
//    comparator + FSM + streak counter + event counter.
//  - Instantiated twice (P, Q); top adds result_valid register and parameter checks.
// TESTING
//  1. Reset, no stimulus -> all outputs 0.
//     Assert rst_n low mid-run with alarm_p=1 -> outputs 0 immediately, without waiting for clk.
//  2. Samples 7,8 (valid every cycle) -> result_valid pulses 1 cycle later; raw_p=raw_q=alarm=0.
//     Sample 6 -> raw_p=1, raw_q=0. Sample 5 -> raw_p=1, raw_q=1. Sample 9 -> raw_p=1, raw_q=0.
//  3. PERSIST=3: samples 11,11,11 -> alarm_p, alarm_q rise with the 3rd result; evt_cnt_p=evt_cnt_q=1.
//     Then 7,7,7 -> both alarms fall with the 3rd result.
//  4. Interrupted streaks (PERSIST=3):
//     - 11,11,7,11,11 -> alarms never assert.
//     - In ALARM, 7,7,11,7,7 -> alarms never clear.
//  5. clear=1 with sample_valid=1 while alarm_p=1, evt_cnt_p=2 -> next cycle:
//     alarms 0, evt_cnts 0, result_valid 0, sample dropped.
//  6. EVT_WIDTH=2, PERSIST=1: 5 alarm episodes (11,7 pairs) -> evt_cnt_p reads 1,2,3,3,3.
//     Idle gaps with sample_valid=0 between samples do not break a streak.

Source files
------------

// File: rtl/blood_ph_monitor_pkg.sv
// Shared definitions for the blood-pH monitor: channel FSM state encodings
// and the default normal-window constants used by the top and its channels.
package blood_ph_monitor_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_PEND_ALARM = 2'd1,
        ST_ALARM      = 2'd2,
        ST_PEND_CLEAR = 2'd3
    } ph_state_e;

    localparam int DEF_PH_WIDTH  = 4;
    localparam int DEF_P_LOW     = 6;
    localparam int DEF_P_HIGH    = 9;
    localparam int DEF_Q_LOW     = 5;
    localparam int DEF_Q_HIGH    = 10;
    localparam int DEF_PERSIST   = 3;
    localparam int DEF_EVT_WIDTH = 8;

endpackage

// File: rtl/blood_ph_monitor_channel.sv
// One pH alarm channel: window comparator, N-sample hysteresis FSM with streak
// counter, and a saturating counter of alarm episodes (alarm 0->1 transitions).
module ph_alarm_channel
    import blood_ph_monitor_pkg::*;
#(
    parameter int PH_WIDTH  = DEF_PH_WIDTH,
    parameter int LOW       = DEF_P_LOW,
    parameter int HIGH      = DEF_P_HIGH,
    parameter int PERSIST   = DEF_PERSIST,
    parameter int EVT_WIDTH = DEF_EVT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid_i,
    input  logic [PH_WIDTH-1:0]  ph_i,
    input  logic                 clear_i,
    output logic                 raw_o,
    output logic                 alarm_o,
    output logic [EVT_WIDTH-1:0] evt_cnt_o,
    output logic [1:0]           state_o
);

    localparam int SW = $clog2(PERSIST + 1);
    localparam logic [PH_WIDTH-1:0]  LOW_C     = PH_WIDTH'(LOW);
    localparam logic [PH_WIDTH-1:0]  HIGH_C    = PH_WIDTH'(HIGH);
    localparam logic [SW-1:0]        PERSIST_C = SW'(PERSIST);
    localparam logic [EVT_WIDTH-1:0] EVT_MAX   = '1;

    ph_state_e            state_q;
    logic [SW-1:0]        streak_q;
    logic                 raw_q;
    logic                 alarm_q;
    logic [EVT_WIDTH-1:0] evt_q;

    logic [PH_WIDTH-1:0]  ph_g;
    logic                 abn;
    logic [SW-1:0]        streak_inc;
    logic                 streak_done;
    logic [EVT_WIDTH-1:0] evt_d;

    // An idle bus is forced to zero so undriven/X samples never reach the compare.
    always_comb begin
        ph_g = sample_valid_i ? ph_i : '0;
        abn  = !((LOW_C < ph_g) && (ph_g < HIGH_C));
    end

    // Pending states never hold more than PERSIST-1, so the increment cannot wrap.
    assign streak_inc  = streak_q + SW'(1);
    assign streak_done = (streak_inc == PERSIST_C);
    assign evt_d       = (evt_q == EVT_MAX) ? evt_q : evt_q + EVT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_NORMAL;
            streak_q <= '0;
            raw_q    <= 1'b0;
            alarm_q  <= 1'b0;
            evt_q    <= '0;
        end else if (clear_i) begin
            state_q  <= ST_NORMAL;
            streak_q <= '0;
            raw_q    <= 1'b0;
            alarm_q  <= 1'b0;
            evt_q    <= '0;
        end else if (sample_valid_i) begin
            raw_q <= abn;
            unique case (state_q)
                ST_NORMAL, ST_PEND_ALARM: begin
                    if (!abn) begin
                        state_q  <= ST_NORMAL;
                        streak_q <= '0;
                    end else if (streak_done) begin
                        state_q  <= ST_ALARM;
                        streak_q <= '0;
                        alarm_q  <= 1'b1;
                        evt_q    <= evt_d;
                    end else begin
                        state_q  <= ST_PEND_ALARM;
                        streak_q <= streak_inc;
                    end
                end
                ST_ALARM, ST_PEND_CLEAR: begin
                    if (abn) begin
                        state_q  <= ST_ALARM;
                        streak_q <= '0;
                    end else if (streak_done) begin
                        state_q  <= ST_NORMAL;
                        streak_q <= '0;
                        alarm_q  <= 1'b0;
                    end else begin
                        state_q  <= ST_PEND_CLEAR;
                        streak_q <= streak_inc;
                    end
                end
            endcase
        end
    end

    assign raw_o     = raw_q;
    assign alarm_o   = alarm_q;
    assign evt_cnt_o = evt_q;
    assign state_o   = state_q;

endmodule

// File: rtl/blood_ph_monitor.sv
// Sequential blood-pH monitor: two independent debounced alarm channels (P, Q)
// behind a one-cycle result_valid strobe; dbg_state = {state_q, state_p}.
module blood_ph_monitor
    import blood_ph_monitor_pkg::*;
#(
    parameter int PH_WIDTH  = DEF_PH_WIDTH,
    parameter int P_LOW     = DEF_P_LOW,
    parameter int P_HIGH    = DEF_P_HIGH,
    parameter int Q_LOW     = DEF_Q_LOW,
    parameter int Q_HIGH    = DEF_Q_HIGH,
    parameter int PERSIST   = DEF_PERSIST,
    parameter int EVT_WIDTH = DEF_EVT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic [PH_WIDTH-1:0]  ph_in,
    input  logic                 clear,
    output logic                 result_valid,
    output logic                 raw_p,
    output logic                 raw_q,
    output logic                 alarm_p,
    output logic                 alarm_q,
    output logic [EVT_WIDTH-1:0] evt_cnt_p,
    output logic [EVT_WIDTH-1:0] evt_cnt_q,
    output logic [3:0]           dbg_state
);

    if (!(P_LOW < P_HIGH) || !(Q_LOW < Q_HIGH) ||
        (P_HIGH >= (1 << PH_WIDTH)) || (Q_HIGH >= (1 << PH_WIDTH)) ||
        (P_LOW < 0) || (Q_LOW < 0) || (PERSIST < 1)) begin : g_bad_params
        $error("blood_ph_monitor: illegal window or PERSIST parameters");
    end

    logic       result_valid_q;
    logic [1:0] state_p;
    logic [1:0] state_qch;

    // A sample presented together with clear is dropped, so no result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= sample_valid && !clear;
        end
    end

    ph_alarm_channel #(
        .PH_WIDTH (PH_WIDTH),
        .LOW      (P_LOW),
        .HIGH     (P_HIGH),
        .PERSIST  (PERSIST),
        .EVT_WIDTH(EVT_WIDTH)
    ) u_chan_p (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid_i(sample_valid),
        .ph_i          (ph_in),
        .clear_i       (clear),
        .raw_o         (raw_p),
        .alarm_o       (alarm_p),
        .evt_cnt_o     (evt_cnt_p),
        .state_o       (state_p)
    );

    ph_alarm_channel #(
        .PH_WIDTH (PH_WIDTH),
        .LOW      (Q_LOW),
        .HIGH     (Q_HIGH),
        .PERSIST  (PERSIST),
        .EVT_WIDTH(EVT_WIDTH)
    ) u_chan_q (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid_i(sample_valid),
        .ph_i          (ph_in),
        .clear_i       (clear),
        .raw_o         (raw_q),
        .alarm_o       (alarm_q),
        .evt_cnt_o     (evt_cnt_q),
        .state_o       (state_qch)
    );

    assign result_valid = result_valid_q;
    assign dbg_state    = {state_qch, state_p};

endmodule

// File: tb/tb_blood_ph_monitor.sv
// Directed bench for blood_ph_monitor: a default instance (PERSIST=3) and a
// small-counter instance (PERSIST=1, EVT_WIDTH=2) share one stimulus bus.
module tb_blood_ph_monitor;

  // sample_valid qualifies ph_in for exactly the cycle it is high; there is no
  // backpressure, results appear one clock later with result_valid high.
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] ph_in = 4'd0;
  logic       clear = 1'b0;

  logic       rv_a, raw_p_a, raw_q_a, alarm_p_a, alarm_q_a;
  logic [7:0] evt_p_a, evt_q_a;
  logic [3:0] dbg_a;

  logic       rv_b, raw_p_b, raw_q_b, alarm_p_b, alarm_q_b;
  logic [1:0] evt_p_b, evt_q_b;
  logic [3:0] dbg_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  blood_ph_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .ph_in(ph_in), .clear(clear),
    .result_valid(rv_a), .raw_p(raw_p_a), .raw_q(raw_q_a), .alarm_p(alarm_p_a),
    .alarm_q(alarm_q_a), .evt_cnt_p(evt_p_a), .evt_cnt_q(evt_q_a), .dbg_state(dbg_a)
  );

  blood_ph_monitor #(.PERSIST(1), .EVT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .ph_in(ph_in), .clear(clear),
    .result_valid(rv_b), .raw_p(raw_p_b), .raw_q(raw_q_b), .alarm_p(alarm_p_b),
    .alarm_q(alarm_q_b), .evt_cnt_p(evt_p_b), .evt_cnt_q(evt_q_b), .dbg_state(dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample on the falling edge; return 1 ns after the capturing edge.
  task automatic send(input logic [3:0] v);
    @(negedge clk);
    sample_valid = 1'b1;
    ph_in = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    ph_in = $urandom_range(15, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear(input logic sv, input logic [3:0] v);
    @(negedge clk);
    clear = 1'b1;
    sample_valid = sv;
    ph_in = v;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic check_alarms_a(input string tag, input logic exp_p, input logic exp_q);
    check({tag, "_alarm_p"}, alarm_p_a, exp_p);
    check({tag, "_alarm_q"}, alarm_q_a, exp_q);
  endtask

  initial begin
    int exp_evt_b[5];
    exp_evt_b = '{1, 2, 3, 3, 3};

    // Reset, no stimulus
    idle(3);
    check("rst_rv", rv_a, 0);
    check("rst_raw", {raw_p_a, raw_q_a}, 0);
    check_alarms_a("rst", 0, 0);
    check("rst_evt", {evt_p_a, evt_q_a}, 0);
    check("rst_state", dbg_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("idle_rv", rv_a, 0);

    // Classification and one-cycle latency
    send(4'd7);
    check("s7_rv", rv_a, 1);
    check("s7_raw", {raw_p_a, raw_q_a}, 2'b00);
    send(4'd8);
    check("s8_rv", rv_a, 1);
    check("s8_raw", {raw_p_a, raw_q_a}, 2'b00);
    check_alarms_a("s8", 0, 0);
    idle(1);
    check("gap_rv", rv_a, 0);
    check("gap_raw_hold", {raw_p_a, raw_q_a}, 2'b00);
    send(4'd6);
    check("s6_raw", {raw_p_a, raw_q_a}, 2'b10);
    check("s6_state", dbg_a, 4'b0001);
    send(4'd5);
    check("s5_raw", {raw_p_a, raw_q_a}, 2'b11);
    check("s5_state", dbg_a, 4'b0101);
    send(4'd9);
    check("s9_raw", {raw_p_a, raw_q_a}, 2'b10);
    check_alarms_a("s9", 1, 0);
    check("s9_evt_p", evt_p_a, 1);
    idle(1);
    check("hold_alarm_p", alarm_p_a, 1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_alarm_p", alarm_p_a, 0);
    check("arst_evt_p", evt_p_a, 0);
    check("arst_raw_p", raw_p_a, 0);
    check("arst_state", dbg_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Persistence: three abnormal samples (with an idle gap) raise both alarms
    send(4'd11);
    send(4'd11);
    check_alarms_a("p2", 0, 0);
    idle(2);
    send(4'd11);
    check_alarms_a("p3", 1, 1);
    check("p3_evt", {evt_p_a, evt_q_a}, {8'd1, 8'd1});
    send(4'd7);
    send(4'd7);
    check_alarms_a("c2", 1, 1);
    check("c2_state", dbg_a, 4'b1111);
    send(4'd7);
    check_alarms_a("c3", 0, 0);
    check("c3_evt", {evt_p_a, evt_q_a}, {8'd1, 8'd1});

    // Interrupted streaks
    send(4'd11);
    send(4'd11);
    send(4'd7);
    check_alarms_a("int_a3", 0, 0);
    send(4'd11);
    send(4'd11);
    check_alarms_a("int_a5", 0, 0);
    send(4'd11);
    check_alarms_a("int_rise", 1, 1);
    check("int_evt", {evt_p_a, evt_q_a}, {8'd2, 8'd2});
    send(4'd7);
    send(4'd7);
    send(4'd11);
    check_alarms_a("int_c3", 1, 1);
    send(4'd7);
    send(4'd7);
    check_alarms_a("int_c5", 1, 1);

    // Synchronous clear with a sample presented at the same edge
    do_clear(1'b1, 4'd11);
    check_alarms_a("clr", 0, 0);
    check("clr_evt", {evt_p_a, evt_q_a}, 0);
    check("clr_rv", rv_a, 0);
    check("clr_raw", {raw_p_a, raw_q_a}, 2'b00);
    check("clr_state", dbg_a, 0);
    send(4'd11);
    send(4'd11);
    check_alarms_a("clr_drop", 0, 0);
    send(4'd7);

    // Saturating episode counter on the PERSIST=1, EVT_WIDTH=2 instance
    do_clear(1'b0, 4'd0);
    check("b_clr_evt", evt_p_b, 0);
    for (int i = 0; i < 5; i++) begin
      send(4'd11);
      check($sformatf("b_ep%0d_alarm", i), alarm_p_b, 1);
      check($sformatf("b_ep%0d_evt", i), evt_p_b, exp_evt_b[i]);
      idle(1);
      send(4'd7);
      check($sformatf("b_ep%0d_clear", i), alarm_p_b, 0);
    end
    send(4'd10);
    check("b_q_high_edge", {raw_p_b, raw_q_b}, 2'b11);
    send(4'd0);
    check("b_zero", {raw_p_b, raw_q_b}, 2'b11);
    check("b_q_evt", evt_q_b, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
